// File: rtl/data_packer.sv
// Packs variable-length slices of incoming vectors into full N-element output vectors.
// Optional DATA_PACKER_STATS_EN adds a 32-bit packed_count of emitted vectors.
module data_packer #(
    parameter int                      N                  = 8,
    parameter int                      DATA_WIDTH         = 32,
    parameter int                      MAX_CHAINS         = 4,
    parameter int                      PERSONAL_CONFIG_ID = 0,
    parameter logic [MAX_CHAINS*8-1:0] INITIAL_FIRMWARE   = '0,
    parameter int                      CHAIN_W            = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             valid_in,
    input  logic                             eof_in,
    input  logic [CHAIN_W-1:0]               chainId_in,
    input  logic                             tracing,
    input  logic [7:0]                       configId,
    input  logic [7:0]                       configData,
    input  logic [N-1:0][DATA_WIDTH-1:0]     vector_in,
    output logic                             valid_out,
    output logic [N-1:0][DATA_WIDTH-1:0]     vector_out,
    output logic                             overflow_err
`ifdef DATA_PACKER_STATS_EN
    ,
    output logic [31:0]                      packed_count
`endif
);

    localparam int CW = $clog2(2*N+1);
    localparam logic [0:0] PACK  = 1'b0;
    localparam logic [0:0] FLUSH = 1'b1;

    logic [0:0]                     state_q, state_d;
    logic [CW-1:0]                  count_q, count_d;
    logic [N-1:0][DATA_WIDTH-1:0]   pack_q, pack_d;
    logic [N-1:0][DATA_WIDTH-1:0]   vec_out_q, vec_out_d;
    logic                           valid_out_q, valid_out_d;
    logic                           ovf_q, ovf_d;
    logic [MAX_CHAINS-1:0][7:0]     fw_q, fw_d;

    logic [2*N-1:0][DATA_WIDTH-1:0] ext;
    logic [7:0]                     fw_sel;
    logic                           accept;
    int                             m, cnt, total;

    // Slice length for the current chain; out-of-range chain ids fall back to a full vector.
    always_comb begin
        fw_sel = 8'd0;
        for (int c = 0; c < MAX_CHAINS; c++)
            if (int'(chainId_in) == c) fw_sel = fw_q[c];
        m = (fw_sel == 8'd0 || int'(fw_sel) >= N) ? N : int'(fw_sel);
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        pack_d      = pack_q;
        vec_out_d   = vec_out_q;
        valid_out_d = 1'b0;
        ovf_d       = ovf_q;
        fw_d        = fw_q;

        cnt    = int'(count_q);
        accept = tracing && valid_in && (state_q == PACK);
        total  = cnt + (accept ? m : 0);

        // Held elements followed by the new slice; every unused slot is zero so padding is free.
        ext = '0;
        for (int i = 0; i < N; i++)
            if (i < cnt) ext[i] = pack_q[i];
        for (int j = 0; j < N; j++)
            if (accept && j < m) ext[cnt+j] = vector_in[j];

        if (!tracing) begin
            // Tracing off freezes datapath and state, FLUSH included; only firmware is writable.
            if (int'(configId) >= PERSONAL_CONFIG_ID &&
                int'(configId) <  PERSONAL_CONFIG_ID + MAX_CHAINS) begin
                for (int c = 0; c < MAX_CHAINS; c++)
                    if (int'(configId) - PERSONAL_CONFIG_ID == c) fw_d[c] = configData;
            end
        end else if (state_q == FLUSH) begin
            for (int i = 0; i < N; i++)
                vec_out_d[i] = (i < cnt) ? pack_q[i] : '0;
            valid_out_d = 1'b1;
            count_d     = '0;
            state_d     = PACK;
            if (valid_in || eof_in) ovf_d = 1'b1;
        end else if (total >= N) begin
            valid_out_d = 1'b1;
            vec_out_d   = ext[N-1:0];
            pack_d      = ext[2*N-1:N];
            count_d     = CW'(total - N);
            if (eof_in && total > N) state_d = FLUSH;
            else if (eof_in)         count_d = '0;
        end else if (eof_in) begin
            if (total > 0) begin
                valid_out_d = 1'b1;
                vec_out_d   = ext[N-1:0];
            end
            count_d = '0;
        end else begin
            pack_d  = ext[N-1:0];
            count_d = CW'(total);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= PACK;
            count_q     <= '0;
            pack_q      <= '0;
            vec_out_q   <= '0;
            valid_out_q <= 1'b0;
            ovf_q       <= 1'b0;
            fw_q        <= INITIAL_FIRMWARE;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            pack_q      <= pack_d;
            vec_out_q   <= vec_out_d;
            valid_out_q <= valid_out_d;
            ovf_q       <= ovf_d;
            fw_q        <= fw_d;
        end
    end

    assign valid_out    = valid_out_q;
    assign vector_out   = vec_out_q;
    assign overflow_err = ovf_q;

`ifdef DATA_PACKER_STATS_EN
    logic [31:0] packed_count_q, packed_count_d;

    always_comb packed_count_d = packed_count_q + {31'd0, valid_out_d};

    always_ff @(posedge clk) begin
        if (reset) packed_count_q <= '0;
        else       packed_count_q <= packed_count_d;
    end

    assign packed_count = packed_count_q;
`endif

endmodule

// File: tb/tb_data_packer.sv
// Directed bench for data_packer (N=8, 32-bit elements, 4 chains, config id base 0).
module tb_data_packer;
    localparam int N  = 8;
    localparam int DW = 32;
    typedef logic [N-1:0][DW-1:0] vec_t;

    logic       clk = 1'b0;
    logic       reset, valid_in, eof_in, tracing;
    logic [1:0] chainId_in;
    logic [7:0] configId, configData;
    vec_t       vector_in, vector_out;
    logic       valid_out, overflow_err;
`ifdef DATA_PACKER_STATS_EN
    logic [31:0] packed_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_packer #(
        .N(N), .DATA_WIDTH(DW), .MAX_CHAINS(4), .PERSONAL_CONFIG_ID(0), .INITIAL_FIRMWARE(32'h0)
    ) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .eof_in(eof_in),
        .chainId_in(chainId_in), .tracing(tracing), .configId(configId),
        .configData(configData), .vector_in(vector_in), .valid_out(valid_out),
        .vector_out(vector_out), .overflow_err(overflow_err)
`ifdef DATA_PACKER_STATS_EN
        , .packed_count(packed_count)
`endif
    );

    task automatic chk(input string tag, input logic [N*DW-1:0] got, input logic [N*DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic vec_t mk(input int base);
        vec_t v;
        for (int i = 0; i < N; i++) v[i] = DW'(base + i);
        return v;
    endfunction

    function automatic vec_t v8(input int a, b, c, d, e, f, g, h);
        int   arr[8];
        vec_t v;
        arr = '{a, b, c, d, e, f, g, h};
        for (int i = 0; i < N; i++) v[i] = DW'(arr[i]);
        return v;
    endfunction

    task automatic cyc(input logic v, input logic e, input logic [1:0] ch, input vec_t d);
        valid_in   = v;
        eof_in     = e;
        chainId_in = ch;
        vector_in  = d;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 2'd0, '0);
    endtask

    task automatic cfg(input logic [7:0] id, input logic [7:0] data);
        tracing    = 1'b0;
        configId   = id;
        configData = data;
        valid_in   = 1'b0;
        eof_in     = 1'b0;
        @(posedge clk); #1;
        tracing  = 1'b1;
        configId = 8'hFF;
    endtask

    initial begin
        // Reset held while a config write is presented: the write must lose.
        reset = 1'b1; tracing = 1'b0; valid_in = 1'b0; eof_in = 1'b0;
        chainId_in = 2'd0; configId = 8'd0; configData = 8'd2; vector_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {255'd0, valid_out}, '0);
        chk("rst_vector", vector_out, '0);
        chk("rst_ovf", {255'd0, overflow_err}, '0);
        reset = 1'b0; configId = 8'hFF; tracing = 1'b1;

        // firmware[0] still 0 -> whole vector taken in one go
        cyc(1'b1, 1'b0, 2'd0, mk(32'hA0));
        chk("init_fw_valid", {255'd0, valid_out}, 256'd1);
        chk("init_fw_vec", vector_out, mk(32'hA0));

        // One element per input, with a tracing-off gap that must be ignored
        cfg(8'd0, 8'd1);
        for (int k = 1; k <= 4; k++) cyc(1'b1, 1'b0, 2'd0, mk(k));
        tracing = 1'b0;
        cyc(1'b1, 1'b1, 2'd0, mk(32'h99));
        chk("trace_off_valid", {255'd0, valid_out}, '0);
        tracing = 1'b1;
        for (int k = 5; k <= 7; k++) cyc(1'b1, 1'b0, 2'd0, mk(k));
        chk("m1_partial_valid", {255'd0, valid_out}, '0);
        cyc(1'b1, 1'b0, 2'd0, mk(8));
        chk("m1_full_valid", {255'd0, valid_out}, 256'd1);
        chk("m1_full_vec", vector_out, v8(1, 2, 3, 4, 5, 6, 7, 8));
        idle();
        chk("m1_idle_valid", {255'd0, valid_out}, '0);
        chk("m1_hold_vec", vector_out, v8(1, 2, 3, 4, 5, 6, 7, 8));

        // Three elements per input, remainder carried then flushed by a bare eof
        cfg(8'd0, 8'd3);
        cyc(1'b1, 1'b0, 2'd0, mk(32'h10));
        cyc(1'b1, 1'b0, 2'd0, mk(32'h20));
        cyc(1'b1, 1'b0, 2'd0, mk(32'h30));
        chk("m3_vec", vector_out, v8('h10, 'h11, 'h12, 'h20, 'h21, 'h22, 'h30, 'h31));
        cyc(1'b0, 1'b1, 2'd0, '0);
        chk("m3_eof_valid", {255'd0, valid_out}, 256'd1);
        chk("m3_eof_vec", vector_out, v8('h32, 0, 0, 0, 0, 0, 0, 0));
        idle();
        chk("m3_after_valid", {255'd0, valid_out}, '0);

        // eof together with the last input, short total -> zero-padded vector
        cfg(8'd0, 8'd1);
        for (int k = 1; k <= 3; k++) cyc(1'b1, 1'b0, 2'd0, mk(k));
        cyc(1'b1, 1'b1, 2'd0, mk(4));
        chk("eof_pad_vec", vector_out, v8(1, 2, 3, 4, 0, 0, 0, 0));
        idle();
        chk("eof_pad_after", {255'd0, valid_out}, '0);

        // eof overshooting N -> FLUSH cycle; input during FLUSH is dropped
        cfg(8'd0, 8'd3);
        cyc(1'b1, 1'b0, 2'd0, mk(32'h40));
        cyc(1'b1, 1'b0, 2'd0, mk(32'h50));
        cyc(1'b1, 1'b1, 2'd0, mk(32'h60));
        chk("flush_full_vec", vector_out, v8('h40, 'h41, 'h42, 'h50, 'h51, 'h52, 'h60, 'h61));
        cyc(1'b1, 1'b0, 2'd0, mk(32'h70));
        chk("flush_rem_valid", {255'd0, valid_out}, 256'd1);
        chk("flush_rem_vec", vector_out, v8('h62, 0, 0, 0, 0, 0, 0, 0));
        chk("flush_ovf", {255'd0, overflow_err}, 256'd1);
        idle();
        chk("flush_after_valid", {255'd0, valid_out}, '0);
        cyc(1'b0, 1'b1, 2'd0, '0);
        chk("flush_dropped", {255'd0, valid_out}, '0);
        chk("ovf_sticky", {255'd0, overflow_err}, 256'd1);
        reset = 1'b1;
        idle();
        reset = 1'b0;
        chk("ovf_cleared", {255'd0, overflow_err}, '0);

        // Chain 1 firmware rewritten to 0 -> full vector
        cfg(8'd1, 8'd5);
        cfg(8'd1, 8'd0);
        cyc(1'b1, 1'b0, 2'd1, mk(9));
        chk("chain1_valid", {255'd0, valid_out}, 256'd1);
        chk("chain1_vec", vector_out, v8(9, 10, 11, 12, 13, 14, 15, 16));

        // Reset mid-pack discards the partial buffer without a flush
        cfg(8'd0, 8'd1);
        for (int k = 1; k <= 5; k++) cyc(1'b1, 1'b0, 2'd0, mk(32'h80 + k));
        reset = 1'b1;
        cyc(1'b1, 1'b1, 2'd0, mk(32'h90));
        chk("midrst_valid", {255'd0, valid_out}, '0);
        reset = 1'b0;
        idle();
        chk("midrst_no_flush", {255'd0, valid_out}, '0);
        cfg(8'd0, 8'd1);
        for (int k = 1; k <= 8; k++) cyc(1'b1, 1'b0, 2'd0, mk(k));
        chk("midrst_valid2", {255'd0, valid_out}, 256'd1);
        chk("midrst_vec", vector_out, v8(1, 2, 3, 4, 5, 6, 7, 8));
`ifdef DATA_PACKER_STATS_EN
        chk("packed_count", {224'd0, packed_count}, 256'd1);
`endif
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_packer.md
DATA_PACKER -- requirements
Module: dataPacker

Interface
REQ-001 SHALL have parameter N, default 8, vector length in elements.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, element width in bits.
REQ-003 SHALL have parameter MAX_CHAINS, default 4, number of per-chain firmware slots.
REQ-004 SHALL have parameter PERSONAL_CONFIG_ID, default 0, first configId owned by this block.
REQ-005 SHALL have parameter INITIAL_FIRMWARE, default all 0, 8-bit per-chain power-up/reset firmware.
REQ-006 SHALL have port clk, input, 1, sole clock; all logic on posedge.
REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have ports valid_in (1), eof_in (1), chainId_in ($clog2(MAX_CHAINS)), tracing (1), configId (8), configData (8), all inputs.
REQ-009 SHALL have port vector_in, input, N x DATA_WIDTH, vector from the upstream reduce stage.
REQ-010 SHALL have ports valid_out (1), vector_out (N x DATA_WIDTH), registered outputs.
REQ-011 SHALL have port overflow_err, output, 1, sticky protocol-violation flag.

Function
REQ-012 SHALL derive M per input from firmware[chainId_in]: 0 or value >= N -> M=N; 1..N-1 -> M=value.
REQ-013 SHALL, when tracing=1 and valid_in=1, append vector_in[0..M-1] to a shared pack buffer behind count held elements, in arrival order, regardless of chain.
REQ-014 SHALL, when count+M >= N, register the N oldest elements to vector_out (index 0 = oldest), assert valid_out for one cycle, and retain the remaining count+M-N elements (0..N-1) as new count.
REQ-015 SHALL provide exactly 1 cycle latency from accepting input to valid_out.
REQ-016 SHALL, on eof_in=1 (with or without valid_in), flush: after any append, if 0 < total < N emit the total elements zero-padded the next cycle; if total = 0 emit nothing.
REQ-017 SHALL, when eof_in coincides with an append giving total > N, emit the full vector next cycle, enter state FLUSH, emit the remainder zero-padded on the following cycle, and return to PACK with count=0.
REQ-018 SHALL use states PACK and FLUSH only; FLUSH lasts exactly one cycle.
REQ-019 SHALL, on valid_in=1 or eof_in=1 while in FLUSH, drop that input and set overflow_err=1 until reset.
REQ-020 SHALL, when tracing=0, hold the buffer and count, drive valid_out=0, and ignore valid_in/eof_in.
REQ-021 SHALL, when tracing=0 and PERSONAL_CONFIG_ID <= configId < PERSONAL_CONFIG_ID+MAX_CHAINS, write firmware[configId-PERSONAL_CONFIG_ID] <= configData, effective next cycle.
REQ-022 SHALL keep vector_out unchanged on cycles where valid_out=0.

Reset
REQ-023 SHALL, on reset=1 at posedge, set valid_out=0, vector_out all zero, count=0, state=PACK, overflow_err=0, firmware=INITIAL_FIRMWARE.
REQ-024 SHALL discard partially packed data on reset mid-operation; no flush output is produced.
REQ-025 SHALL give reset priority over tracing, configuration, and data inputs.

Configuration
REQ-026 SHALL, when DATA_PACKER_STATS_EN is defined, add output packed_count (32 bits), reset to 0, incremented by 1 per valid_out cycle, wrapping 0xFFFFFFFF -> 0.
REQ-027 SHALL, when DATA_PACKER_STATS_EN is undefined, omit packed_count port and counter entirely, with otherwise identical behaviour.

Verification (N=8, DATA_WIDTH=32, MAX_CHAINS=4, PERSONAL_CONFIG_ID=0)
REQ-028 SHALL cover: firmware[0]=1, 8 valid inputs with vector_in[0]=1..8 -> single valid_out one cycle after 8th input, vector_out=[1,2,3,4,5,6,7,8].
REQ-029 SHALL cover: firmware[0]=3, inputs A,B,C -> vector_out=[A0,A1,A2,B0,B1,B2,C0,C1] after C, count=1 holding C2.
REQ-030 SHALL cover: firmware[0]=1, values 1,2,3 then 4 with eof_in -> vector_out=[1,2,3,4,0,0,0,0], then no further output.
REQ-031 SHALL cover: firmware[0]=3, A,B,C with eof on C -> full vector, next cycle [C2,0,0,0,0,0,0,0]; valid_in during that FLUSH cycle -> input dropped, overflow_err=1.
REQ-032 SHALL cover: tracing=0, configId=1, configData=0, then tracing=1 and chain-1 vector [9..16] with empty buffer -> vector_out=[9..16] one cycle later.
REQ-033 SHALL cover: firmware[0]=1, 5 inputs then reset -> no valid_out; then 8 inputs 1..8 -> vector_out=[1..8].
